// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: arbiter state and client enums, line geometry
// and the tag fields clients place in bus_reqtag.
package sysbus_pkg;

  localparam int unsigned LINE_BEATS     = 8;
  localparam int unsigned BEAT_WIDTH     = 64;
  localparam int unsigned LINE_WIDTH     = LINE_BEATS * BEAT_WIDTH;
  localparam int unsigned BEAT_CNT_WIDTH = $clog2(LINE_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RRESP,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    CLIENT_FETCH = 1'b0,
    CLIENT_MM    = 1'b1
  } arb_client_t;

  // Tag layout: bit 12 selects read/write, bits 11:8 select the device.
  localparam int unsigned SYSBUS_RW_BIT  = 12;
  localparam logic        SYSBUS_READ    = 1'b1;
  localparam logic        SYSBUS_WRITE   = 1'b0;
  localparam int unsigned SYSBUS_DEV_LSB = 8;
  localparam logic [3:0]  SYSBUS_MEMORY  = 4'b0001;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the client not served last wins.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic f_req,
  input  logic m_req,
  input  logic update,
  input  logic served_mm,
  output logic grant_valid,
  output logic grant_mm
);
  import sysbus_pkg::*;

  arb_client_t last;

  // Grant decision from current requests and the last-served client.
  always_comb begin
    grant_valid = f_req | m_req;
    grant_mm    = m_req & (~f_req | (last == CLIENT_FETCH));
  end

  // Remember which client completed most recently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last <= CLIENT_FETCH;
    else if (update) last <= served_mm ? CLIENT_MM : CLIENT_FETCH;
  end

endmodule

// File: rtl/sysbus_line_arbiter.sv
// Arbitrates whole-line reads/writes from fetch and mm onto the single
// Sysbus port, one transaction outstanding at a time.
module sysbus_line_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned ADDRESS_WIDTH  = 64,
  parameter int unsigned LINE_BEATS     = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 f_req,
  input  logic                                 f_we,
  input  logic [ADDRESS_WIDTH-1:0]             f_addr,
  input  logic [BUS_TAG_WIDTH-1:0]             f_tag,
  input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] f_wdata,
  output logic                                 f_done,
  output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] f_rdata,
  input  logic                                 m_req,
  input  logic                                 m_we,
  input  logic [ADDRESS_WIDTH-1:0]             m_addr,
  input  logic [BUS_TAG_WIDTH-1:0]             m_tag,
  input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] m_wdata,
  output logic                                 m_done,
  output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] m_rdata,
  output logic                                 busy,
  output logic                                 bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]            bus_req,
  output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
  input  logic                                 bus_reqack,
  input  logic                                 bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag,
  output logic                                 bus_respack
);
  import sysbus_pkg::*;

  localparam int unsigned LINE_W = BUS_DATA_WIDTH * LINE_BEATS;
  localparam int unsigned CW     = $clog2(LINE_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);

  arb_state_t  state;
  arb_client_t owner;
  logic              we;
  logic [LINE_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic              grant_valid;
  logic              grant_mm;

  // bus_resptag is deliberately unused: only one transaction is ever in flight.

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .f_req       (f_req),
    .m_req       (m_req),
    .update      (state == ST_DONE),
    .served_mm   (owner == CLIENT_MM),
    .grant_valid (grant_valid),
    .grant_mm    (grant_mm)
  );

  // Status and response-side handshake derived from the current state.
  always_comb begin
    busy        = (state != ST_IDLE);
    bus_respack = (state == ST_RRESP) & bus_respcyc;
  end

  // Transaction FSM: grant, address beat, write beats or read collection, done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= CLIENT_FETCH;
      we         <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
      f_done     <= 1'b0;
      m_done     <= 1'b0;
      f_rdata    <= '0;
      m_rdata    <= '0;
    end else begin
      f_done <= 1'b0;
      m_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner      <= grant_mm ? CLIENT_MM : CLIENT_FETCH;
            we         <= grant_mm ? m_we : f_we;
            wdata_q    <= grant_mm ? m_wdata : f_wdata;
            bus_req    <= BUS_DATA_WIDTH'(grant_mm ? m_addr : f_addr);
            bus_reqtag <= grant_mm ? m_tag : f_tag;
            bus_reqcyc <= 1'b1;
            state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus_reqack) begin
            cnt <= '0;
            if (we) begin
              bus_req <= wdata_q[0 +: BUS_DATA_WIDTH];
              state   <= ST_WDATA;
            end else begin
              bus_reqcyc <= 1'b0;
              state      <= ST_RRESP;
            end
          end
        end
        ST_WDATA: begin
          if (bus_reqack) begin
            if (cnt == LAST_BEAT) begin
              bus_reqcyc <= 1'b0;
              f_done     <= (owner == CLIENT_FETCH);
              m_done     <= (owner == CLIENT_MM);
              state      <= ST_DONE;
            end else begin
              cnt     <= cnt + 1'b1;
              bus_req <= wdata_q[BUS_DATA_WIDTH*(int'(cnt) + 1) +: BUS_DATA_WIDTH];
            end
          end
        end
        ST_RRESP: begin
          if (bus_respcyc) begin
            if (owner == CLIENT_MM) m_rdata[BUS_DATA_WIDTH*int'(cnt) +: BUS_DATA_WIDTH] <= bus_resp;
            else                    f_rdata[BUS_DATA_WIDTH*int'(cnt) +: BUS_DATA_WIDTH] <= bus_resp;
            if (cnt == LAST_BEAT) begin
              f_done <= (owner == CLIENT_FETCH);
              m_done <= (owner == CLIENT_MM);
              state  <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
